edge_pattern_gen: RTL

Command-driven waveform generator: the transmit-side counterpart of `edge_detector`. It accepts a queue of (level, duration) commands over a valid/ready handshake and drives `signal_out` with exact per-cycle hold times. The result is a programmable single-wire pattern source whose edges downstream edge detectors consume. It sits between a sequencing controller and any logic that samples a single-bit control line.

---
 rtl/edge_gen_pkg.sv | 20 ++
 rtl/edge_cmd_fifo.sv | 62 ++++++
 rtl/edge_pattern_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg
// Shared types for the edge pattern generator.
//   DUR_W_DEF        : default width of the hold-duration field
//   edge_cmd_t       : one queued command {level, dur}
//   edge_gen_state_e : player FSM states, exposed on the debug port
package edge_gen_pkg;

    localparam int DUR_W_DEF = 8;

    typedef struct packed {
        logic                 level;
        logic [DUR_W_DEF-1:0] dur;
    } edge_cmd_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } edge_gen_state_e;

endpackage

// File: rtl/edge_cmd_fifo.sv
// edge_cmd_fifo
// Synchronous command FIFO with an occupancy counter and first-word
// read: pop_data always shows the head entry while the FIFO is non-empty.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : consume the head entry (ignored when empty)
//   pop_data            : current head entry
//   full, empty         : derived from the registered count
module edge_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen
// Command-driven single-wire waveform generator. Queued (level, duration)
// commands are played back-to-back on signal_out, each held for exactly
// max(dur,1) cycles.
// Optional feature macro: EDGE_GEN_FLAGS_EN adds rise_flag / fall_flag.
// Handshake: a command is taken on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on FIFO occupancy, never
// on cmd_valid, and the source must hold its command stable until taken.
// Ports:
//   clk, rst             : clock, synchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_level, cmd_dur   : command payload (dur 0 plays as 1)
//   signal_out           : generated waveform (registered)
//   busy                 : a command is being held
//   done                 : one-cycle pulse after the last queued hold
//   rise_flag, fall_flag : edge pulses aligned with signal_out (optional)
//   state_dbg            : current FSM state
module edge_pattern_gen
    import edge_gen_pkg::*;
#(
    parameter int DUR_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_level,
    input  logic [DUR_W-1:0] cmd_dur,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
`ifdef EDGE_GEN_FLAGS_EN
    output logic             rise_flag,
    output logic             fall_flag,
`endif
    output edge_gen_state_e  state_dbg
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q;
    logic [DUR_W-1:0] cnt_q;
    logic             out_q;
    logic             done_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DUR_W:0]   head;
    logic             head_level;
    logic [DUR_W-1:0] head_dur;
    logic [DUR_W-1:0] load_cnt;
    logic             pop;

    // The FIFO stores raw {level, dur} bits so non-default DUR_W works too.
    edge_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (DUR_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_level, cmd_dur}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_level = head[DUR_W];
    assign head_dur   = head[DUR_W-1:0];
    // cnt counts remaining extra cycles, so a zero duration still holds one.
    assign load_cnt   = (head_dur == '0) ? '0 : head_dur - 1'b1;

    // Load from IDLE, or reload on the last hold cycle: no gap between
    // commands.
    assign pop = !fifo_empty && ((state_q == ST_IDLE) || (cnt_q == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                out_q   <= head_level;
                cnt_q   <= load_cnt;
                state_q <= ST_HOLD;
            end else if (state_q == ST_HOLD) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    // Queue drained: level is kept, only the state returns.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

`ifdef EDGE_GEN_FLAGS_EN
    logic rise_q;
    logic fall_q;

    // Registered alongside out_q so each pulse lands in the first cycle
    // the new level is visible; same-level reloads give no pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= pop && head_level && !out_q;
            fall_q <= pop && !head_level && out_q;
        end
    end

    assign rise_flag = rise_q;
    assign fall_flag = fall_q;
`endif

    assign cmd_ready  = !fifo_full;
    assign signal_out = out_q;
    assign busy       = (state_q == ST_HOLD);
    assign done       = done_q;
    assign state_dbg  = edge_gen_state_e'(state_q);

endmodule
